// File: rtl/pipe_pkg.sv
// Shared types and sizing helpers for the fetch-stage PC sequencer.
package pipe_pkg;

  localparam int PC_WIDE_DEF = 7;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Counter must hold FLUSH_CYCLES itself, so size for n+1 values.
  function automatic int cnt_width(input int flush_cycles);
    return (flush_cycles < 1) ? 1 : $clog2(flush_cycles + 1);
  endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Truncating adder: branch target = base + low PC_WIDE bits of the offset.
module branch_target_calc #(
  parameter int PC_WIDE = pipe_pkg::PC_WIDE_DEF
) (
  input  logic [PC_WIDE-1:0] base,
  input  logic [PC_WIDE-1:0] offset,
  output logic [PC_WIDE-1:0] target
);

  assign target = base + offset;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage controller: owns the PC, sequences RUN/STALL/FLUSH/HALT,
// and drives fetch enable plus the same-cycle branch flush strobes.
module pc_sequencer
  import pipe_pkg::*;
#(
  parameter int                PC_WIDE      = PC_WIDE_DEF,
  parameter int                FLUSH_CYCLES = 2,
  parameter logic [PC_WIDE-1:0] RESET_PC    = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               halt_i,
  input  logic               branch_valid_i,
  input  logic               branch_taken_i,
  input  logic [PC_WIDE-1:0] branch_base_i,
  input  logic [31:0]        branch_offset_i,
  output logic [PC_WIDE-1:0] pc_o,
  output logic [PC_WIDE-1:0] pc_next_o,
  output logic               fetch_en_o,
  output logic               flush_ifid_o,
  output logic               flush_idex_o,
  output logic               halted_o
);

  localparam int CNT_W = cnt_width(FLUSH_CYCLES);

  state_t             state, state_nxt;
  logic [PC_WIDE-1:0] pc_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [PC_WIDE-1:0] target;
  logic               redir;
  logic               fetch_raw;
  logic               unused_offset_hi;

  // Displacement bits above the PC width can never affect a modulo-2^PC_WIDE sum.
  assign unused_offset_hi = ^branch_offset_i[31:PC_WIDE];

  branch_target_calc #(.PC_WIDE(PC_WIDE)) u_target (
    .base   (branch_base_i),
    .offset (branch_offset_i[PC_WIDE-1:0]),
    .target (target)
  );

  assign redir = !rst && branch_valid_i && branch_taken_i &&
                 (state == ST_RUN || state == ST_STALL);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_o;
    cnt_nxt   = cnt;
    fetch_raw = 1'b0;
    case (state)
      ST_RUN: begin
        fetch_raw = 1'b1;
        if (redir) begin
          pc_nxt    = target;
          cnt_nxt   = CNT_W'(FLUSH_CYCLES);
          state_nxt = ST_FLUSH;
        end else if (halt_i) begin
          state_nxt = ST_HALT;
        end else if (stall_i) begin
          state_nxt = ST_STALL;
        end else begin
          pc_nxt = pc_o + PC_WIDE'(1);
        end
      end
      ST_STALL: begin
        if (redir) begin
          pc_nxt    = target;
          cnt_nxt   = CNT_W'(FLUSH_CYCLES);
          state_nxt = ST_FLUSH;
        end else if (halt_i) begin
          state_nxt = ST_HALT;
        end else if (!stall_i) begin
          // Resume without incrementing: the held address has not been fetched yet.
          state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          cnt_nxt   = '0;
          state_nxt = stall_i ? ST_STALL : ST_RUN;
        end
      end
      ST_HALT: ;
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      pc_o  <= RESET_PC;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      pc_o  <= pc_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign pc_next_o    = pc_o + PC_WIDE'(1);
  assign fetch_en_o   = !rst && fetch_raw;
  assign flush_ifid_o = redir;
  assign flush_idex_o = redir;
  assign halted_o     = !rst && (state == ST_HALT);

endmodule
